recog_seq_ctrl: RTL
===================

Name: recog_seq_ctrl

Overview:
Frame-level sequencer for the digit-recognition pipeline. It runs three phases over video frames: projection, border readback/settle, and feature frame. It drives project_done_flag, frame_cnt, num_row and num_col into the recognition datapath, then captures its digit bus and returns it through a valid/ready handshake. It sits between the timing generator and projection block on one side and the recognition block and user logic on the other.

Parameters:
NUM_ROW, 1, max digit rows supported.
NUM_COL, 3, max digit columns supported.
NUM_WIDTH, (NUM_ROW*NUM_COL*4)-1, MSB index of the digit bus.
TIMEOUT_FRAMES, 8, frames allowed in the projection phase before it aborts; range 2..255.

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous active-high reset
vsync  in  1  frame sync, level; a rising edge marks the frame start
start  in  1  one-cycle request to begin a recognition run
continuous  in  1  1 = restart automatically after each result
proj_done  in  1  projection block finished the current frame (pulse)
det_rows  in  4  row count detected by projection
det_cols  in  4  column count detected by projection
digit_in  in  NUM_WIDTH+1  digit bus from the recognition block
proj_en  out  1  enables projection accumulation
project_done_flag  out  1  to recognition block
frame_cnt  out  2  to recognition block
num_row  out  4  latched row count
num_col  out  4  latched column count
result  out  NUM_WIDTH+1  captured digits
result_valid  out  1  result available
result_ready  in  1  consumer accepts the result
busy  out  1  high in every state except IDLE
err  out  2  sticky error code: 0 none, 1 timeout, 2 bad count

Behaviour:
- Reset, synchronous, active-high, overriding every other input:
  - state = IDLE.
  - All outputs 0.
  - err is cleared.
- vsync edge detect:
  - vs_d is registered; fs = vsync & ~vs_d.
  - fs is a one-cycle pulse and is the only frame event.
- IDLE:
  - start=1 → WAIT_FS.
  - On the same edge, err is cleared.
- WAIT_FS:
  - On fs → PROJECT.
  - proj_en=1 and the frame timer is cleared on the same edge.
- PROJECT:
  - proj_en stays 1.
  - The frame timer increments on each fs; it is 8 bits and saturates.
  - If proj_done → CHECK; proj_en drops next cycle.
  - Else if timer == TIMEOUT_FRAMES → err=1, then IDLE, or WAIT_FS if continuous.
  - proj_done and the timeout condition on the same cycle: proj_done wins.
- CHECK (one cycle):
  - Valid when 1 ≤ det_rows ≤ NUM_ROW and 1 ≤ det_cols ≤ NUM_COL.
  - Valid → num_row/num_col latch det_rows/det_cols, project_done_flag=1, frame_cnt=0, → RECOG.
  - Invalid → err=2, then IDLE, or WAIT_FS if continuous.
- RECOG:
  - Each fs increments frame_cnt: 0→1→2.
  - The fs that would advance frame_cnt from 2 → CAPTURE. frame_cnt stays at 2 during that cycle.
  - num_row and num_col are held constant for the whole phase.
- CAPTURE (one cycle):
  - result ← digit_in.
  - result_valid=1.
  - project_done_flag=0, frame_cnt=0.
  - → HOLD.
- HOLD:
  - result_valid and result stay stable until result_valid & result_ready.
  - On that handshake, result_valid clears next cycle, then → WAIT_FS if continuous, else IDLE.
  - result_ready while result_valid=0 is ignored.
- start is ignored outside IDLE.
- Dropping continuous mid-run affects only the next decision point.
- Latency:
  - From the CHECK cycle to result_valid: three fs events + 1 cycle. The first two fs events advance frame_cnt to 1 and 2; the third fs, which ends the feature frame, enters CAPTURE.
  - result_valid rises one cycle after that third fs.
- Reset mid-run aborts immediately: project_done_flag=0 and no result_valid.

Optional Feature:
STABLE_RESULT_EN
- Defined: CAPTURE compares digit_in with the previously captured value.
  - On mismatch: store digit_in as the new previous value, keep project_done_flag=1, set frame_cnt=0, → RECOG for another feature pass. No result_valid.
  - result_valid is raised only when two consecutive passes match.
  - The previous value is invalidated on reset and on entry to PROJECT.
- Undefined: a single pass produces the result, as described above.

Decomposition:
- Package recog_pkg:
  - state enum: IDLE, WAIT_FS, PROJECT, CHECK, RECOG, CAPTURE, HOLD.
  - err code constants: ERR_NONE=0, ERR_TIMEOUT=1, ERR_COUNT=2.
  - FRAME_FEATURE=2'd2.
- Sub-module frame_edge_det: vsync register plus the fs pulse.
- FSM, timer and result holding register stay in the top module.

Test Plan:
1. start; fs; proj_done with det_rows=1, det_cols=3; three more fs; digit_in=12'h507 on the third; result_ready=1 → result=12'h507, result_valid 1 cycle after the third fs; frame_cnt sequence 0,1,2; busy then low.
2. start; no proj_done for 8 fs → err=1, proj_en=0, IDLE; project_done_flag never asserted.
3. proj_done with det_cols=4 (NUM_COL=3) → err=2, num_col unchanged; same with det_rows=0.
4. result_ready=0 for 20 cycles after capture, continuous=1 → result_valid and result stable; after ready, WAIT_FS, then the next run starts.
5. rst=1 during RECOG with frame_cnt=1 → next edge: all outputs 0, state IDLE; start pulse while busy → ignored.
6. STABLE_RESULT_EN: digit_in 12'h123 then 12'h124 then 12'h124 → one result_valid with 12'h124, after the third pass.

Source files
------------

// File: rtl/recog_pkg.sv
// Shared types and constants for the digit-recognition frame sequencer.
// Optional build macro used by the sequencer: STABLE_RESULT_EN.
package recog_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_FS = 3'd1,
        PROJECT = 3'd2,
        CHECK   = 3'd3,
        RECOG   = 3'd4,
        CAPTURE = 3'd5,
        HOLD    = 3'd6
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_COUNT   = 2'd2;

    // Last frame_cnt value of the feature phase; the next fs ends the pass.
    localparam logic [1:0] FRAME_FEATURE = 2'd2;

    // A detected count is usable when it is non-zero and fits the datapath.
    function automatic logic count_ok(input logic [3:0] v, input int unsigned max_v);
        return (v != 4'd0) && (32'(v) <= max_v);
    endfunction

endpackage

// File: rtl/frame_edge_det.sv
// Registers vsync and produces a one-cycle frame-start pulse on its rising edge.
module frame_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    output logic fs
);

    logic vs_d;

    always_ff @(posedge clk) begin
        if (rst) vs_d <= 1'b0;
        else     vs_d <= vsync;
    end

    assign fs = vsync & ~vs_d;

endmodule

// File: rtl/recog_seq_ctrl.sv
// Frame sequencer: projection, count check, three-frame feature pass, result handshake.
// Build macro STABLE_RESULT_EN: repeat feature passes until two consecutive captures agree.
module recog_seq_ctrl
    import recog_pkg::*;
#(
    parameter int NUM_ROW        = 1,
    parameter int NUM_COL        = 3,
    parameter int NUM_WIDTH      = (NUM_ROW * NUM_COL * 4) - 1,
    parameter int TIMEOUT_FRAMES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vsync,
    input  logic                 start,
    input  logic                 continuous,
    input  logic                 proj_done,
    input  logic [3:0]           det_rows,
    input  logic [3:0]           det_cols,
    input  logic [NUM_WIDTH:0]   digit_in,
    output logic                 proj_en,
    output logic                 project_done_flag,
    output logic [1:0]           frame_cnt,
    output logic [3:0]           num_row,
    output logic [3:0]           num_col,
    output logic [NUM_WIDTH:0]   result,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 busy,
    output logic [1:0]           err,
    output state_t               state_dbg
);

    // Handshake: result_valid rises with a new result and holds result stable;
    // a transfer happens on any cycle where result_valid & result_ready are both 1,
    // and result_valid drops on the following cycle. result_ready alone is ignored.

    localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT_FRAMES);

    logic fs;

    frame_edge_det u_edge (
        .clk   (clk),
        .rst   (rst),
        .vsync (vsync),
        .fs    (fs)
    );

    state_t             state, state_n;
    logic [7:0]         timer, timer_n;
    logic               pdf_n;
    logic [1:0]         frame_cnt_n;
    logic [3:0]         num_row_n, num_col_n;
    logic [NUM_WIDTH:0] result_n;
    logic               result_valid_n;
    logic [1:0]         err_n;
`ifdef STABLE_RESULT_EN
    logic [NUM_WIDTH:0] prev_val, prev_val_n;
    logic               prev_ok, prev_ok_n;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            timer             <= 8'd0;
            project_done_flag <= 1'b0;
            frame_cnt         <= 2'd0;
            num_row           <= 4'd0;
            num_col           <= 4'd0;
            result            <= '0;
            result_valid      <= 1'b0;
            err               <= ERR_NONE;
`ifdef STABLE_RESULT_EN
            prev_val          <= '0;
            prev_ok           <= 1'b0;
`endif
        end else begin
            state             <= state_n;
            timer             <= timer_n;
            project_done_flag <= pdf_n;
            frame_cnt         <= frame_cnt_n;
            num_row           <= num_row_n;
            num_col           <= num_col_n;
            result            <= result_n;
            result_valid      <= result_valid_n;
            err               <= err_n;
`ifdef STABLE_RESULT_EN
            prev_val          <= prev_val_n;
            prev_ok           <= prev_ok_n;
`endif
        end
    end

    always_comb begin
        state_n        = state;
        timer_n        = timer;
        pdf_n          = project_done_flag;
        frame_cnt_n    = frame_cnt;
        num_row_n      = num_row;
        num_col_n      = num_col;
        result_n       = result;
        result_valid_n = result_valid;
        err_n          = err;
`ifdef STABLE_RESULT_EN
        prev_val_n     = prev_val;
        prev_ok_n      = prev_ok;
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    state_n = WAIT_FS;
                    err_n   = ERR_NONE;
                end
            end

            WAIT_FS: begin
                if (fs) begin
                    state_n = PROJECT;
                    timer_n = 8'd0;
`ifdef STABLE_RESULT_EN
                    prev_ok_n = 1'b0;
`endif
                end
            end

            PROJECT: begin
                if (fs && timer != 8'hFF) timer_n = timer + 8'd1;
                // proj_done takes priority over a timeout on the same cycle.
                if (proj_done) begin
                    state_n = CHECK;
                end else if (timer == TIMEOUT_VAL) begin
                    err_n   = ERR_TIMEOUT;
                    state_n = continuous ? WAIT_FS : IDLE;
                end
            end

            CHECK: begin
                if (count_ok(det_rows, NUM_ROW) && count_ok(det_cols, NUM_COL)) begin
                    num_row_n   = det_rows;
                    num_col_n   = det_cols;
                    pdf_n       = 1'b1;
                    frame_cnt_n = 2'd0;
                    state_n     = RECOG;
                end else begin
                    err_n   = ERR_COUNT;
                    state_n = continuous ? WAIT_FS : IDLE;
                end
            end

            RECOG: begin
                if (fs) begin
                    if (frame_cnt == FRAME_FEATURE) state_n = CAPTURE;
                    else                            frame_cnt_n = frame_cnt + 2'd1;
                end
            end

            CAPTURE: begin
                frame_cnt_n = 2'd0;
`ifdef STABLE_RESULT_EN
                if (prev_ok && digit_in == prev_val) begin
                    result_n       = digit_in;
                    result_valid_n = 1'b1;
                    pdf_n          = 1'b0;
                    state_n        = HOLD;
                end else begin
                    prev_val_n = digit_in;
                    prev_ok_n  = 1'b1;
                    state_n    = RECOG;
                end
`else
                result_n       = digit_in;
                result_valid_n = 1'b1;
                pdf_n          = 1'b0;
                state_n        = HOLD;
`endif
            end

            HOLD: begin
                if (result_valid && result_ready) begin
                    result_valid_n = 1'b0;
                    state_n        = continuous ? WAIT_FS : IDLE;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    assign proj_en   = (state == PROJECT);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule
